hex_display_scanner: RTL

Time-multiplexed controller for a multi-digit 7-segment display that shares one hex_decoder instance across NUM_DIGITS digits. It cycles a one-hot digit select and blanks the display briefly between digits to prevent ghosting. New display values arrive through a valid/ready load port. They are double-buffered and applied only at a frame boundary, so the display never shows a torn value.

---
 rtl/hex_display_scanner_pkg.sv | 17 +
 rtl/hex_display_scanner_if.sv | 13 +
 rtl/hex_display_scanner_decoder.sv | 28 ++
 rtl/hex_display_scanner.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/hex_display_scanner_pkg.sv
// Shared types and width helper for the multiplexed hex display scanner.
package hex_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Register width for a count of n values, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Valid/ready load port carrying a full set of display nibbles.
interface hex_display_scanner_if #(
  parameter int unsigned NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] value_in;
  logic                    load;
  logic                    ready;

  modport master (output value_in, output load, input ready);
  modport slave  (input value_in, input load, output ready);

endinterface

// File: rtl/hex_display_scanner_decoder.sv
// Combinational hex-to-7-segment decoder, active-low, bit0 = a ... bit6 = g.
module hex_decoder (
  input  logic [3:0] c,
  output logic [6:0] display
);

  always_comb begin
    unique case (c)
      4'h0:    display = 7'h40;
      4'h1:    display = 7'h79;
      4'h2:    display = 7'h24;
      4'h3:    display = 7'h30;
      4'h4:    display = 7'h19;
      4'h5:    display = 7'h12;
      4'h6:    display = 7'h02;
      4'h7:    display = 7'h78;
      4'h8:    display = 7'h00;
      4'h9:    display = 7'h10;
      4'hA:    display = 7'h08;
      4'hB:    display = 7'h03;
      4'hC:    display = 7'h46;
      4'hD:    display = 7'h21;
      4'hE:    display = 7'h06;
      default: display = 7'h0E;
    endcase
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed 7-segment scanner with double-buffered, frame-aligned value updates.
// Optional build macro LEADING_ZERO_BLANK_EN suppresses leading zeros on digits above 0.
module hex_display_scanner
  import hex_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  hex_display_scanner_if.slave  bus,
  output logic [6:0]            seg_out,
  output logic [NUM_DIGITS-1:0] digit_sel
);

  localparam int unsigned CNT_W = width_of(REFRESH_DIV);
  localparam int unsigned IDX_W = width_of(NUM_DIGITS);
  localparam int unsigned VAL_W = 4 * NUM_DIGITS;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [VAL_W-1:0]        active_q, active_d;
  logic [VAL_W-1:0]        pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic [3:0]              nibble;
  logic [6:0]              dec_seg;
  logic                    lead_zero;
  logic                    accept;
  logic                    frame_wrap;

  always_comb begin
    nibble = active_q[3:0];
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) nibble = active_q[4*k +: 4];
    end
  end

  hex_decoder u_decoder (
    .c       (nibble),
    .display (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    lead_zero = 1'b0;
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) lead_zero = ((active_q >> (4*k)) == '0);
    end
  end
`else
  assign lead_zero = 1'b0;
`endif

  assign accept    = bus.load && !pending_valid_q;
  assign bus.ready = !pending_valid_q;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    state_d         = state_q;
    idx_d           = idx_q;
    cnt_d           = cnt_q;
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    seg_d           = SEG_BLANK;
    sel_d           = '0;
    frame_wrap      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending_valid_q) begin
          active_d        = pending_q;
          pending_valid_d = 1'b0;
        end else if (accept) begin
          active_d = bus.value_in;
        end
        if (enable) begin
          state_d = SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end

      SHOW, BLANK: begin
        if (!enable) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (state_q == SHOW) begin
          seg_d = lead_zero ? SEG_BLANK : dec_seg;
          sel_d = NUM_DIGITS'(1) << idx_q;
          if (cnt_q == SHOW_LAST) begin
            state_d = BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (cnt_q == BLANK_LAST) begin
          state_d    = SHOW;
          cnt_d      = '0;
          frame_wrap = (idx_q == IDX_LAST);
          idx_d      = frame_wrap ? '0 : idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        // Values only reach the display at a frame boundary; otherwise they wait in pending.
        if (frame_wrap && pending_valid_q) begin
          active_d        = pending_q;
          pending_valid_d = 1'b0;
        end else if (frame_wrap && accept) begin
          active_d = bus.value_in;
        end else if (accept) begin
          pending_d       = bus.value_in;
          pending_valid_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      cnt_q           <= '0;
      active_q        <= '0;
      pending_valid_q <= 1'b0;
      seg_q           <= SEG_BLANK;
      sel_q           <= '0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      cnt_q           <= cnt_d;
      active_q        <= active_d;
      pending_valid_q <= pending_valid_d;
      seg_q           <= seg_d;
      sel_q           <= sel_d;
    end
  end

  // NOTE: pending_q is pure data qualified by pending_valid_q, so it carries no reset.
  always_ff @(posedge clock) begin
    pending_q <= pending_d;
  end

  assign seg_out   = seg_q;
  assign digit_sel = sel_q;

endmodule
